// File: rtl/mio_bus_arbiter.sv
// Two-master (CPU / DMA) single-bus arbiter: one transaction at a time,
// round-robin or CPU-priority tie-break, bus timeout abort with sticky error.
module mio_bus_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned TIMEOUT      = 15,
    parameter bit          CPU_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [1:0]        grant,
    output logic              timeout_err,
    output logic              err_sticky,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_grant;
    logic              r_last_dma;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_cnt;
    logic              r_abort;
    logic              r_err;
    logic              w_any_req;
    logic              w_pick_cpu;
    logic              w_timeout;

    assign w_any_req  = cpu_req | dma_req;
    // On a tie the CPU wins under priority mode, or when DMA owned the bus last.
    assign w_pick_cpu = cpu_req & (~dma_req | CPU_PRIORITY | r_last_dma);
    assign w_timeout  = (r_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next = ST_BUSY;
            ST_BUSY: if (bus_ack || w_timeout) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= '0;
            r_last_dma <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_pick_cpu ? 2'b01 : 2'b10;
                        r_last_dma <= ~w_pick_cpu;
                        r_we       <= w_pick_cpu ? cpu_we    : dma_we;
                        r_addr     <= w_pick_cpu ? cpu_addr  : dma_addr;
                        r_wdata    <= w_pick_cpu ? cpu_wdata : dma_wdata;
                        r_cnt      <= '0;
                        r_abort    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        r_rdata <= bus_rdata;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_abort <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_grant <= '0;
                    r_abort <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        dma_ready   = 1'b0;
        dma_rdata   = '0;
        timeout_err = 1'b0;
        case (r_state)
            ST_BUSY: begin
                bus_req   = 1'b1;
                bus_we    = r_we;
                bus_addr  = r_addr;
                bus_wdata = r_wdata;
            end
            ST_RESP: begin
                cpu_ready   = r_grant[0];
                cpu_rdata   = r_grant[0] ? r_rdata : '0;
                dma_ready   = r_grant[1];
                dma_rdata   = r_grant[1] ? r_rdata : '0;
                timeout_err = r_abort;
            end
            default: ;
        endcase
    end

    assign grant      = r_grant;
    assign err_sticky = r_err;
    assign state_out  = r_state;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: directed vector table, contention/timeout sequences,
// and random traffic checked against a transaction-schedule model.
module tb_mio_bus_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, bus_ack;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, bus_rdata;

    logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
    logic        cpu_ready, dma_ready, bus_req, bus_we, timeout_err, err_sticky;
    logic [1:0]  grant, state_out;

    logic [31:0] p_cpu_rdata, p_dma_rdata, p_bus_addr, p_bus_wdata;
    logic        p_cpu_ready, p_dma_ready, p_bus_req, p_bus_we, p_timeout_err, p_err_sticky;
    logic [1:0]  p_grant, p_state_out;

    logic [137:0] act;
    assign act = {grant, state_out, bus_req, bus_we, bus_addr, bus_wdata,
                  cpu_ready, cpu_rdata, dma_ready, dma_rdata, timeout_err, err_sticky};

    mio_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO), .CPU_PRIORITY(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .grant(grant), .timeout_err(timeout_err), .err_sticky(err_sticky), .state_out(state_out)
    );

    mio_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO), .CPU_PRIORITY(1'b1)) u_dut_p (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(p_cpu_rdata), .cpu_ready(p_cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(p_dma_rdata), .dma_ready(p_dma_ready),
        .bus_req(p_bus_req), .bus_we(p_bus_we), .bus_addr(p_bus_addr), .bus_wdata(p_bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .grant(p_grant), .timeout_err(p_timeout_err), .err_sticky(p_err_sticky),
        .state_out(p_state_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [137:0] got, input logic [137:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        ack;
        logic [31:0] rdata;
        logic [1:0]  st;
        logic [1:0]  gr;
        logic        breq;
        logic [31:0] baddr;
        logic        rdy;
        logic [31:0] crd;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic req, input logic [31:0] addr,
                                input logic ack, input logic [31:0] rd, input logic [1:0] st,
                                input logic [1:0] gr, input logic breq, input logic [31:0] ba,
                                input logic rdy, input logic [31:0] crd);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.ack = ack; v.rdata = rd;
        v.st = st; v.gr = gr; v.breq = breq; v.baddr = ba; v.rdy = rdy; v.crd = crd;
        return v;
    endfunction

    // Transaction-schedule model: a grant sampled in idle cycle g puts the bus in
    // BUSY for cycles g+1..g+L and the response in cycle g+L+1.
    bit          tx_act = 1'b0;
    int          g = 0, L = 0, tx_d = 0, owner = 0, last = 2;
    bit          tx_abort = 1'b0, m_sticky = 1'b0;
    logic        tx_we = 1'b0;
    logic [31:0] tx_addr = '0, tx_wdata = '0, tx_data = '0;

    function automatic logic [137:0] model_out(input int c);
        logic [1:0]  gr, st;
        logic        br, bw, cr, dr, te;
        logic [31:0] ba, bd, crd, drd, rd;
        gr = '0; st = 2'd0; br = 1'b0; bw = 1'b0; ba = '0; bd = '0;
        cr = 1'b0; dr = 1'b0; crd = '0; drd = '0; te = 1'b0; rd = '0;
        if (tx_act && c >= g + 1 && c <= g + L) begin
            gr = (owner == 1) ? 2'b01 : 2'b10;
            st = 2'd1; br = 1'b1; bw = tx_we; ba = tx_addr; bd = tx_wdata;
        end else if (tx_act && c == g + L + 1) begin
            gr = (owner == 1) ? 2'b01 : 2'b10;
            st = 2'd2;
            rd = tx_abort ? 32'h0 : tx_data;
            cr = (owner == 1); dr = (owner == 2);
            crd = cr ? rd : 32'h0;
            drd = dr ? rd : 32'h0;
            te = tx_abort;
        end
        return {gr, st, br, bw, ba, bd, cr, crd, dr, drd, te, m_sticky};
    endfunction

    vec_t tbl[13];

    initial begin
        int cnt;
        bit idle, busy_now, resp_now;
        int winner;

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        tick();
        tick();

        // rst, req, addr, ack, rdata | state, grant, bus_req, bus_addr, cpu_ready, cpu_rdata
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         2'd0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         2'd1, 2'b01, 1'b1, 32'h40, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b1, 32'h40, 1'b1, 32'h8C01_0004, 2'd2, 2'b01, 1'b0, 32'h0,  1'b1, 32'h8C01_0004);
        tbl[3]  = mk(1'b0, 1'b0, 32'h40, 1'b0, 32'h0,         2'd0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0);
        tbl[4]  = mk(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         2'd1, 2'b01, 1'b1, 32'h40, 1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 1'b1, 32'h80, 1'b0, 32'h0,         2'd1, 2'b01, 1'b1, 32'h40, 1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b1, 32'h80, 1'b1, 32'h1111_2222, 2'd2, 2'b01, 1'b0, 32'h0,  1'b1, 32'h1111_2222);
        tbl[7]  = mk(1'b0, 1'b0, 32'h80, 1'b0, 32'h0,         2'd0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,         2'd1, 2'b01, 1'b1, 32'h40, 1'b0, 32'h0);
        tbl[9]  = mk(1'b1, 1'b1, 32'h40, 1'b0, 32'h0,         2'd0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0);
        tbl[10] = mk(1'b0, 1'b1, 32'h44, 1'b0, 32'h0,         2'd1, 2'b01, 1'b1, 32'h44, 1'b0, 32'h0);
        tbl[11] = mk(1'b0, 1'b1, 32'h44, 1'b1, 32'h0000_A5A5, 2'd2, 2'b01, 1'b0, 32'h0,  1'b1, 32'h0000_A5A5);
        tbl[12] = mk(1'b0, 1'b0, 32'h44, 1'b0, 32'h0,         2'd0, 2'b00, 1'b0, 32'h0,  1'b0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; cpu_req = tbl[i].req; cpu_addr = tbl[i].addr;
            bus_ack = tbl[i].ack; bus_rdata = tbl[i].rdata;
            tick();
            check($sformatf("tbl[%0d]", i),
                  {state_out, grant, bus_req, bus_addr, cpu_ready, cpu_rdata, dma_ready},
                  {tbl[i].st, tbl[i].gr, tbl[i].breq, tbl[i].baddr, tbl[i].rdy, tbl[i].crd, 1'b0});
        end

        // Contention: both held; round-robin alternates, priority instance keeps the CPU.
        reset = 1'b1; bus_ack = 1'b0; tick(); reset = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 32'h100; dma_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            bus_ack = 1'b0;
            tick();
            tick();
            bus_ack = 1'b1; bus_rdata = 32'hC0DE_0000 + 32'(k);
            tick();
            check($sformatf("rr_resp%0d", k), {grant, cpu_ready, dma_ready, cpu_rdata, dma_rdata},
                  (k % 2 == 0) ? {2'b01, 1'b1, 1'b0, 32'hC0DE_0000 + 32'(k), 32'h0}
                               : {2'b10, 1'b0, 1'b1, 32'h0, 32'hC0DE_0000 + 32'(k)});
            check($sformatf("prio_resp%0d", k), {p_grant, p_cpu_ready, p_dma_ready, p_cpu_rdata},
                  {2'b01, 1'b1, 1'b0, 32'hC0DE_0000 + 32'(k)});
            bus_ack = 1'b0;
            tick();
            check($sformatf("ready_pulse%0d", k),
                  {cpu_ready, dma_ready, p_cpu_ready, p_dma_ready, state_out}, 6'b0);
        end

        // DMA write to a slave that never acknowledges.
        reset = 1'b1; tick(); reset = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1;
        dma_addr = 32'hE000_0000; dma_wdata = 32'h1234_5678; bus_ack = 1'b0;
        tick();
        check("to_bus", {bus_req, bus_we, bus_addr, bus_wdata, grant}, {1'b1, 1'b1, 32'hE000_0000, 32'h1234_5678, 2'b10});
        cnt = 0;
        while (bus_req && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_len", 138'(cnt), 138'(TO));
        check("to_resp", {dma_ready, timeout_err, dma_rdata, cpu_ready, err_sticky, state_out},
              {1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 2'd2});
        dma_req = 1'b0; dma_we = 1'b0; bus_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("to_sticky", {err_sticky, timeout_err, state_out}, {1'b1, 1'b0, 2'd0});
        bus_ack = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        check("to_clear", act, 138'h0);

        // Random traffic against the schedule model.
        cpu_req = 1'b0; dma_req = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        tx_act = 1'b0; last = 2; m_sticky = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            idle     = !tx_act || (it >= g + L + 2);
            busy_now = tx_act && it >= g + 1 && it <= g + L;
            resp_now = tx_act && it == g + L + 1;
            if (cpu_req && resp_now && owner == 1) begin
                cpu_req = 1'($urandom_range(1, 0));
                cpu_we = 1'($urandom_range(1, 0)); cpu_addr = $urandom; cpu_wdata = $urandom;
            end else if (!cpu_req && $urandom_range(2, 0) == 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(1, 0)); cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (dma_req && resp_now && owner == 2) begin
                dma_req = 1'($urandom_range(1, 0));
                dma_we = 1'($urandom_range(1, 0)); dma_addr = $urandom; dma_wdata = $urandom;
            end else if (!dma_req && $urandom_range(2, 0) == 0) begin
                dma_req = 1'b1;
                dma_we = 1'($urandom_range(1, 0)); dma_addr = $urandom; dma_wdata = $urandom;
            end
            bus_rdata = $urandom;
            if (busy_now) begin
                bus_ack = (it == g + tx_d);
                if (bus_ack) tx_data = bus_rdata;
            end else begin
                bus_ack = ($urandom_range(3, 0) == 0);
            end
            reset = ($urandom_range(63, 0) == 0);

            if (reset) begin
                tx_act = 1'b0; m_sticky = 1'b0; last = 2;
            end else if (idle && (cpu_req || dma_req)) begin
                if (cpu_req && dma_req) winner = (last == 2) ? 1 : 2;
                else winner = cpu_req ? 1 : 2;
                owner = winner; last = winner; g = it; tx_act = 1'b1;
                tx_d = ($urandom_range(5, 0) == 0) ? int'($urandom_range(TO + 3, TO))
                                                   : int'($urandom_range(4, 1));
                tx_abort = (tx_d > TO);
                L = tx_abort ? TO : tx_d;
                tx_we    = (winner == 1) ? cpu_we    : dma_we;
                tx_addr  = (winner == 1) ? cpu_addr  : dma_addr;
                tx_wdata = (winner == 1) ? cpu_wdata : dma_wdata;
            end
            tick();
            if (tx_act && tx_abort && it + 1 == g + L + 1) m_sticky = 1'b1;
            check($sformatf("rand@%0d", it + 1), act, model_out(it + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
